// File: rtl/pattern_sequencer_pkg.sv
// Shared types and width helpers for the pattern sequencer and its step timer.
package pattern_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_CONT    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   localparam int DEF_NUM_CH  = 2;
   localparam int DEF_NUM_PAT = 4;
   localparam int DEF_DEPTH   = 12;
   localparam int DEF_DIV_W   = 8;

   // Index width for n entries, never below one bit so single-entry builds stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_sequencer_step_timer.sv
// Per-step cycle counter: each step lasts div+1 cycles, o_tick marks the last one.
module step_timer
   import pattern_seq_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div_q;
   logic [DIV_W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == r_div_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_div_q <= '0;
      end else if (i_load) begin
         r_cnt   <= '0;
         r_div_q <= i_div;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Multi-channel pattern sequencer: plays one of NUM_PAT writable step tables on z,
// with programmable length, step duration, one-shot/continuous mode and wrap-time pattern switching.
module pattern_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int                NUM_CH   = DEF_NUM_CH,
   parameter int                NUM_PAT  = DEF_NUM_PAT,
   parameter int                DEPTH    = DEF_DEPTH,
   parameter int                DIV_W    = DEF_DIV_W,
   parameter logic [NUM_CH-1:0] IDLE_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         mode,
   input  logic [idx_w(NUM_PAT)-1:0]    sel,
   input  logic [idx_w(DEPTH+1)-1:0]    len,
   input  logic [DIV_W-1:0]             div,
   input  logic                         wr_en,
   input  logic [idx_w(NUM_PAT)-1:0]    wr_pat,
   input  logic [idx_w(DEPTH)-1:0]      wr_idx,
   input  logic [NUM_CH-1:0]            wr_data,
   output logic [NUM_CH-1:0]            z,
   output logic                         busy,
   output logic [idx_w(DEPTH)-1:0]      step_idx,
   output logic                         wrap,
   output logic                         done
);

   localparam int SEL_W = idx_w(NUM_PAT);
   localparam int LEN_W = idx_w(DEPTH + 1);
   localparam int IDX_W = idx_w(DEPTH);

   logic [NUM_CH-1:0] r_table [NUM_PAT][DEPTH];

   state_t            r_state, w_state_next;
   logic [SEL_W-1:0]  r_sel_q, w_sel_next, w_fetch_pat;
   logic              r_mode_q;
   logic [IDX_W-1:0]  r_last_q, r_step, w_step_next, w_fetch_idx, w_last;
   logic [LEN_W-1:0]  w_len_eff;
   logic [NUM_CH-1:0] r_z;
   logic              r_wrap, r_done;
   logic              w_go, w_tick, w_end, w_leave, w_run;
   logic              w_fetch, w_idle_z, w_wrap_next, w_done_next;

   assign w_run     = (r_state == ST_RUN);
   assign w_go      = (r_state == ST_IDLE) && start && !stop;
   assign w_len_eff = ((len == '0) || (len > LEN_W'(DEPTH))) ? LEN_W'(DEPTH) : len;
   assign w_last    = IDX_W'(w_len_eff - LEN_W'(1));
   assign w_end     = w_run && w_tick && (r_step == r_last_q);
   assign w_leave   = w_run && (w_state_next == ST_IDLE);

   step_timer #(.DIV_W(DIV_W)) u_step_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_go),
      .i_clear (w_leave),
      .i_en    (w_run),
      .i_div   (div),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_go) w_state_next = ST_RUN;
         ST_RUN:  if (stop || (w_end && (r_mode_q == MODE_ONESHOT))) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Stop takes priority over the final-step edge, so it never produces done or wrap.
   always_comb begin
      w_step_next = r_step;
      w_sel_next  = r_sel_q;
      w_fetch     = 1'b0;
      w_fetch_pat = r_sel_q;
      w_fetch_idx = r_step;
      w_idle_z    = 1'b0;
      w_wrap_next = 1'b0;
      w_done_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_go) begin
               w_step_next = '0;
               w_sel_next  = sel;
               w_fetch     = 1'b1;
               w_fetch_pat = sel;
               w_fetch_idx = '0;
            end
         end
         ST_RUN: begin
            if (stop) begin
               w_idle_z    = 1'b1;
               w_step_next = '0;
            end else if (w_end) begin
               w_step_next = '0;
               if (r_mode_q == MODE_CONT) begin
                  w_sel_next  = sel;
                  w_fetch     = 1'b1;
                  w_fetch_pat = sel;
                  w_fetch_idx = '0;
                  w_wrap_next = 1'b1;
               end else begin
                  w_idle_z    = 1'b1;
                  w_done_next = 1'b1;
               end
            end else if (w_tick) begin
               w_step_next = r_step + IDX_W'(1);
               w_fetch     = 1'b1;
               w_fetch_idx = r_step + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_step   <= '0;
         r_sel_q  <= '0;
         r_mode_q <= MODE_CONT;
         r_last_q <= '0;
         r_z      <= IDLE_VAL;
         r_wrap   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_step  <= w_step_next;
         r_sel_q <= w_sel_next;
         r_wrap  <= w_wrap_next;
         r_done  <= w_done_next;
         if (w_go) begin
            r_mode_q <= mode;
            r_last_q <= w_last;
         end
         if (w_fetch)       r_z <= r_table[w_fetch_pat][w_fetch_idx];
         else if (w_idle_z) r_z <= IDLE_VAL;
      end
   end

   // Table is deliberately not reset; a same-edge fetch sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(DEPTH)) && ({1'b0, wr_pat} < (SEL_W+1)'(NUM_PAT)))
         r_table[wr_pat][wr_idx] <= wr_data;
   end

   assign z        = r_z;
   assign busy     = w_run;
   assign step_idx = r_step;
   assign wrap     = r_wrap;
   assign done     = r_done;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: one-shot, continuous, switching, stop, length clamp, write/reset.
module tb_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, stop, mode, wr_en;
   logic [1:0] sel, wr_pat, z;
   logic [3:0] len, wr_idx, step_idx;
   logic [7:0] div;
   logic [1:0] wr_data;
   logic       busy, wrap, done;

   int checks = 0;
   int errors = 0;

   logic [1:0] p0 [12];
   logic [1:0] replay [4];

   always #5 clk = ~clk;

   pattern_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .sel      (sel),
      .len      (len),
      .div      (div),
      .wr_en    (wr_en),
      .wr_pat   (wr_pat),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .z        (z),
      .busy     (busy),
      .step_idx (step_idx),
      .wrap     (wrap),
      .done     (done)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] p, input logic [3:0] i, input logic [1:0] d);
      wr_en = 1'b1; wr_pat = p; wr_idx = i; wr_data = d;
      tick();
      wr_en = 1'b0;
      $display("write table[%0d][%0d] = %0d", p, i, d);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_z"}, z, 8'd0);
      chk({tag, "_busy"}, busy, 8'd0);
      chk({tag, "_step"}, step_idx, 8'd0);
      chk({tag, "_wrap"}, wrap, 8'd0);
      chk({tag, "_done"}, done, 8'd0);
   endtask

   initial begin
      p0 = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      replay = '{2'd3, 2'd3, 2'd0, 2'd1};
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; sel = 2'd0;
      len = 4'd4; div = 8'd0; wr_en = 1'b0; wr_pat = 2'd0; wr_idx = 4'd0; wr_data = 2'd0;
      tick(); tick();
      chk_reset("reset");
      $display("reset checked");
      rst = 1'b0;

      for (int i = 0; i < 12; i++) wr(2'd0, 4'(i), p0[i]);
      wr(2'd1, 4'd0, 2'd1); wr(2'd1, 4'd1, 2'd1); wr(2'd1, 4'd2, 2'd2); wr(2'd1, 4'd3, 2'd2);

      // One-shot, len 4, div 0
      sel = 2'd0; len = 4'd4; div = 8'd0; mode = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t1_z", z, 8'(p0[k]));
         chk("t1_busy", busy, 8'd1);
         chk("t1_step", step_idx, 8'(k));
         tick();
      end
      chk("t1_done", done, 8'd1); chk("t1_zidle", z, 8'd0); chk("t1_busy_lo", busy, 8'd0);
      tick();
      chk("t1_done_pulse", done, 8'd0);
      $display("oneshot len4 div0 done");

      // Continuous, div 2: each value 3 cycles, wrap after 12
      div = 8'd2; mode = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         chk("t2_z", z, 8'(p0[c/3]));
         chk("t2_wrap_lo", wrap, 8'd0);
         tick();
      end
      chk("t2_wrap_z", z, 8'd3); chk("t2_wrap", wrap, 8'd1); chk("t2_wrap_step", step_idx, 8'd0);
      tick();
      chk("t2_wrap_pulse", wrap, 8'd0); chk("t2_z_after", z, 8'd3);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("t2_stopped", busy, 8'd0);
      $display("continuous div2 done");

      // Pattern switch deferred to wrap; start in RUN ignored
      div = 8'd0; mode = 1'b0; sel = 2'd0; start = 1'b1;
      tick(); start = 1'b0;
      chk("t3_s0", z, 8'd3); tick();
      chk("t3_s1", z, 8'd2); sel = 2'd1; tick();
      chk("t3_s2_old", z, 8'd0); start = 1'b1; tick(); start = 1'b0;
      chk("t3_s3_old", z, 8'd1); chk("t3_start_ign", step_idx, 8'd3); chk("t3_busy", busy, 8'd1);
      tick();
      chk("t3_wrap_z", z, 8'd1); chk("t3_wrap", wrap, 8'd1); tick();
      chk("t3_p1_s1", z, 8'd1); chk("t3_p1_step", step_idx, 8'd1); tick();
      chk("t3_p1_s2", z, 8'd2); tick();
      chk("t3_p1_s3", z, 8'd2); chk("t3_p1_step3", step_idx, 8'd3); tick();
      chk("t3_wrap2", wrap, 8'd1); chk("t3_wrap2_z", z, 8'd1); tick();
      tick();
      chk("t3_pre_stop", step_idx, 8'd2);
      $display("pattern switch done");

      // Stop mid-run, start+stop in IDLE, stop on final edge
      stop = 1'b1; tick(); stop = 1'b0;
      chk_reset("t4_stop");
      tick();
      chk("t4_nodone", done, 8'd0); chk("t4_nowrap", wrap, 8'd0);
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("t4_both_busy", busy, 8'd0); chk("t4_both_z", z, 8'd0); tick();
      chk("t4_both_busy2", busy, 8'd0);
      sel = 2'd0; len = 4'd1; mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      chk("t4_l1_z", z, 8'd3); chk("t4_l1_busy", busy, 8'd1);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("t4_final_nodone", done, 8'd0); chk("t4_final_busy", busy, 8'd0); chk("t4_final_z", z, 8'd0);
      $display("stop cases done");

      // Length clamp: len 0 and len 15 both play all 12 steps
      for (int n = 0; n < 2; n++) begin
         len = (n == 0) ? 4'd0 : 4'd15; mode = 1'b1; div = 8'd0; start = 1'b1;
         tick(); start = 1'b0;
         for (int k = 0; k < 12; k++) begin
            chk("t5_z", z, 8'(p0[k]));
            chk("t5_step", step_idx, 8'(k));
            chk("t5_busy", busy, 8'd1);
            tick();
         end
         chk("t5_done", done, 8'd1); chk("t5_busy_lo", busy, 8'd0);
         $display("len %0d played 12 steps", len);
      end
      len = 4'd1; mode = 1'b0; div = 8'd1; start = 1'b1;
      tick(); start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         chk("t5_l1c_z", z, 8'd3);
         chk("t5_l1c_wrap", wrap, 8'((c >= 3) && (c % 2 == 1)));
         tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      $display("len1 continuous done");

      // Same-edge write returns old data; rst mid-run keeps table
      len = 4'd4; div = 8'd0; mode = 1'b0; sel = 2'd0; start = 1'b1;
      tick(); start = 1'b0;
      chk("t6_s0", z, 8'd3);
      wr(2'd0, 4'd1, 2'd3);
      chk("t6_old", z, 8'd2); tick(); tick(); tick();
      chk("t6_wrap", wrap, 8'd1); tick();
      chk("t6_new", z, 8'd3); chk("t6_new_step", step_idx, 8'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_reset("t6_rst");
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t6_replay", z, 8'(replay[k]));
         tick();
      end
      chk("t6_done", done, 8'd1);
      $display("write/reset replay done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
